// File: rtl/quad_enc_pkg.sv
// Shared types and Gray-code step decoding for the quadrature encoder array.
package quad_enc_pkg;

  typedef logic signed [1:0] step_t;

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_t;

  typedef struct packed {
    step_t step;
    logic  illegal;
  } dec_t;

  // {A,B} levels in forward order
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  function automatic logic [1:0] gray_idx(input logic [1:0] s);
    logic [1:0] idx;
    case (s)
      GRAY_S0: idx = 2'd0;
      GRAY_S1: idx = 2'd1;
      GRAY_S2: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Distance around the Gray ring: +1 forward, 3 (i.e. -1) reverse, 2 is a double-bit jump.
  function automatic dec_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    dec_t       res;
    logic [1:0] diff;
    diff        = gray_idx(cur) - gray_idx(prev);
    res.step    = 2'sd0;
    res.illegal = 1'b0;
    case (diff)
      2'd1:    res.step = 2'sd1;
      2'd3:    res.step = -2'sd1;
      2'd2:    res.illegal = 1'b1;
      default: res.step = 2'sd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: synchroniser, glitch filter, arm FSM, step decode,
// position counter, saturating window accumulator and sticky error flag.
module quad_enc_channel
  import quad_enc_pkg::*;
#(
  parameter int unsigned SPD_W = 32,
  parameter int unsigned POS_W = 32,
  parameter int unsigned FILT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             pos_clr_i,
  input  logic             err_clr_i,
  input  logic             tick_i,
  output logic [SPD_W-1:0] speed_o,
  output logic [POS_W-1:0] position_o,
  output logic             err_o
);

  localparam int unsigned CNT_W = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};

  logic [1:0]       sync1_q, sync2_q, vld_q;
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] run_q [2];
  logic [CNT_W-1:0] run_d [2];
  logic [1:0]       prev_q, prev_d;
  arm_t             arm_q, arm_d;
  logic [SPD_W-1:0] acc_q, acc_d, speed_q, speed_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             err_q, err_d;

  dec_t             dec;
  step_t            step;
  logic             illegal;
  logic             settled;
  logic [SPD_W:0]   acc_sum;
  logic [SPD_W-1:0] acc_sat;
  logic [POS_W-1:0] pos_step;

  // Per-pin run counter: accept a new level after FILT consecutive differing samples.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      filt_d[p] = filt_q[p];
      run_d[p]  = '0;
      if (sync2_q[p] != filt_q[p]) begin
        if (run_q[p] == CNT_W'(FILT - 1)) filt_d[p] = sync2_q[p];
        else                              run_d[p]  = run_q[p] + CNT_W'(1);
      end
    end
  end

  assign settled = vld_q[1] && (sync2_q == filt_q);

  // Arm FSM and decode; decoding the filter's next level keeps latency at 2+FILT.
  always_comb begin
    arm_d   = arm_q;
    prev_d  = prev_q;
    step    = 2'sd0;
    illegal = 1'b0;
    dec     = decode_step(prev_q, filt_d);
    case (arm_q)
      ST_DISARMED: begin
        if (settled) begin
          arm_d  = ST_ARMED;
          prev_d = filt_q;
        end
      end
      ST_ARMED: begin
        step    = dec.step;
        illegal = dec.illegal;
        prev_d  = filt_d;
      end
      default: arm_d = ST_DISARMED;
    endcase
  end

  // Position, saturating accumulator, window capture and sticky error.
  always_comb begin
    pos_step = {{(POS_W-2){step[1]}}, step};
    acc_sum  = {acc_q[SPD_W-1], acc_q} + {{(SPD_W-1){step[1]}}, step};
    acc_sat  = acc_sum[SPD_W-1:0];
    if (acc_sum[SPD_W] != acc_sum[SPD_W-1]) acc_sat = acc_sum[SPD_W] ? SPD_MIN : SPD_MAX;

    pos_d   = pos_clr_i ? pos_step : pos_q + pos_step;
    speed_d = speed_q;
    acc_d   = acc_sat;
    if (tick_i) begin
      speed_d = acc_sat;
      acc_d   = '0;
    end

    err_d = err_q;
    if (illegal)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
      filt_q  <= '0;
      for (int p = 0; p < 2; p++) run_q[p] <= '0;
      prev_q  <= '0;
      arm_q   <= ST_DISARMED;
      acc_q   <= '0;
      speed_q <= '0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      filt_q  <= filt_d;
      for (int p = 0; p < 2; p++) run_q[p] <= run_d[p];
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      acc_q   <= acc_d;
      speed_q <= speed_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  assign speed_o    = speed_q;
  assign position_o = pos_q;
  assign err_o      = err_q;

endmodule

// File: rtl/quad_encoder_array.sv
// Multi-channel x4 quadrature decoder; all channels share one speed window timer.
module quad_encoder_array
  import quad_enc_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned SPD_W  = 32,
  parameter int unsigned POS_W  = 32,
  parameter int unsigned WINDOW = 500_000,
  parameter int unsigned FILT   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            a,
  input  logic [N_CH-1:0]            b,
  input  logic [N_CH-1:0]            pos_clr,
  input  logic [N_CH-1:0]            err_clr,
  output logic [N_CH-1:0][SPD_W-1:0] speed,
  output logic [N_CH-1:0][POS_W-1:0] position,
  output logic                       sample_valid,
  output logic [N_CH-1:0]            err
);

  localparam int unsigned TMR_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tick;
  logic             sv_q;

  assign tick  = (tmr_q == TMR_W'(WINDOW - 1));
  assign tmr_d = tick ? '0 : tmr_q + TMR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= '0;
      sv_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      sv_q  <= tick;
    end
  end

  assign sample_valid = sv_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    quad_enc_channel #(
      .SPD_W (SPD_W),
      .POS_W (POS_W),
      .FILT  (FILT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .a_i        (a[g]),
      .b_i        (b[g]),
      .pos_clr_i  (pos_clr[g]),
      .err_clr_i  (err_clr[g]),
      .tick_i     (tick),
      .speed_o    (speed[g]),
      .position_o (position[g]),
      .err_o      (err[g])
    );
  end

endmodule
